shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl_pkg.sv | 20 ++
 rtl/shift_ctrl_shift_step.sv | 35 +++
 rtl/shift_ctrl.sv | 113 +++++++++++
 tb/tb_shift_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg
// Shared encodings for the shift controller: shift operation codes and
// FSM state codes. Imported by shift_ctrl and shift_ctrl_shift_step.
// Build option: SHIFT_CTRL_ROT_EN (see shift_ctrl_shift_step).
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_ctrl_shift_step.sv
// shift_ctrl_shift_step
// Combinational single-bit shift of an 8-bit value.
// Ports:
//   val_in  [7:0]  value to shift
//   op             shift operation (op_e)
//   val_out [7:0]  value shifted by one bit
// Build option: SHIFT_CTRL_ROT_EN -- when defined, OP_ROR rotates right
// (bit0 -> bit7); when undefined, OP_ROR is a plain logical right shift
// and no rotate path exists.
module shift_ctrl_shift_step
    import shift_ctrl_pkg::*;
(
    input  logic [7:0] val_in,
    input  op_e        op,
    output logic [7:0] val_out
);

    always_comb begin
        val_out = val_in;
        case (op)
            OP_LSL: val_out = {val_in[6:0], 1'b0};
            OP_LSR: val_out = {1'b0, val_in[7:1]};
            OP_ASR: val_out = {val_in[7], val_in[7:1]};
            OP_ROR: begin
`ifdef SHIFT_CTRL_ROT_EN
                val_out = {val_in[0], val_in[7:1]};
`else
                val_out = {1'b0, val_in[7:1]};
`endif
            end
            default: val_out = val_in;
        endcase
    end

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl
// Sequenced 8-bit shifter: on an accepted start, loads d_in and shifts it
// one bit per clock, amt times, using the latched operation, then pulses
// done for one cycle.
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        command request, sampled only in IDLE
//   op   [1:0]   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   amt  [2:0]   shift distance 0..7
//   d_in [7:0]   operand loaded on accepted start
//   busy         high whenever not IDLE
//   done         one-cycle completion pulse
//   q    [7:0]   registered working/result value
// Build option: SHIFT_CTRL_ROT_EN enables rotate for op 11 (otherwise LSR).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start; q holds last result
// ST_SHIFT | shifting q one bit per clock, cnt counts down
// ST_DONE  | result stable, done pulsed for this one cycle
module shift_ctrl
    import shift_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] amt,
    input  logic [7:0] d_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] q
);

    state_e     state_q, state_d;
    logic [7:0] q_q, q_d;
    logic [2:0] cnt_q, cnt_d;
    op_e        op_q, op_d;
    logic [7:0] step_out;

    shift_ctrl_shift_step u_step (
        .val_in  (q_q),
        .op      (op_q),
        .val_out (step_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            q_q     <= 8'h00;
            cnt_q   <= 3'd0;
            op_q    <= OP_LSL;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Zero distance skips SHIFT so done follows the accept directly.
                    state_d = (amt != 3'd0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                // cnt==1 means this edge performs the last shift.
                if (cnt_q == 3'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d   = d_in;
                    cnt_d = amt;
                    op_d  = op_e'(op);
                end
            end
            ST_SHIFT: begin
                q_d   = step_out;
                cnt_d = cnt_q - 3'd1;
            end
            default: begin
                q_d   = q_q;
                cnt_d = cnt_q;
                op_d  = op_q;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    assign q = q_q;

endmodule

// File: tb/tb_shift_ctrl.sv
module tb_shift_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] d_in;
    logic       busy;
    logic       done;
    logic [7:0] q;

    int pass_cnt  = 0;
    int total_cnt = 0;

    shift_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .amt     (amt),
        .d_in    (d_in),
        .busy    (busy),
        .done    (done),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge. Issues one command, scrambles the inputs after
    // acceptance, optionally pulses start with d_in=FF at cycle glitch_k,
    // and returns cycles from accept to done plus busy-cycle count.
    task automatic run_cmd(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d,
                           input int glitch_k,
                           output int lat, output int busy_n, output logic [7:0] q_done);
        start = 1'b1; op = o; amt = a; d_in = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; amt = ~a; d_in = ~d;
        lat = 0;
        busy_n = 0;
        while (done !== 1'b1 && lat < 30) begin
            if (busy === 1'b1) busy_n++;
            if (lat == glitch_k) begin
                start = 1'b1; d_in = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) busy_n++;
        q_done = q;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b1; start = 1'b0; op = 2'b00; amt = 3'd0; d_in = 8'h00;
        #3 reset_n = 1'b0;
        #1;
        total_cnt++; if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        start = 1'b1; op = 2'b00; amt = 3'd1; d_in = 8'h01;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL first_accept_busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (q !== 8'h01) $display("FAIL first_accept_q: got %h want 01", q); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b1 || q !== 8'h02)
            $display("FAIL first_cmd_done: got done=%b q=%h want done=1 q=02", done, q); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_lsl;
        int lat, bn; logic [7:0] qd;
        run_cmd(2'b00, 3'd3, 8'h03, -1, lat, bn, qd);
        total_cnt++; if (lat !== 3) $display("FAIL lsl_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (bn !== 4) $display("FAIL lsl_busy_cycles: got %0d want 4", bn); else pass_cnt++;
        total_cnt++; if (qd !== 8'h18) $display("FAIL lsl_q: got %h want 18", qd); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h18)
            $display("FAIL lsl_after: got done=%b busy=%b q=%h want 0 0 18", done, busy, q); else pass_cnt++;
    endtask

    task automatic test_asr_lsr;
        int lat, bn; logic [7:0] qd;
        run_cmd(2'b10, 3'd2, 8'h90, -1, lat, bn, qd);
        total_cnt++; if (qd !== 8'hE4) $display("FAIL asr_q: got %h want e4", qd); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL asr_latency: got %0d want 2", lat); else pass_cnt++;
        @(negedge clk);
        run_cmd(2'b01, 3'd2, 8'h90, -1, lat, bn, qd);
        total_cnt++; if (qd !== 8'h24) $display("FAIL lsr_q: got %h want 24", qd); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_rot;
        int lat, bn; logic [7:0] qd; logic [7:0] exp_q;
`ifdef SHIFT_CTRL_ROT_EN
        exp_q = 8'hC0;
`else
        exp_q = 8'h40;
`endif
        run_cmd(2'b11, 3'd1, 8'h81, -1, lat, bn, qd);
        total_cnt++; if (qd !== exp_q) $display("FAIL op11_q: got %h want %h", qd, exp_q); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL op11_latency: got %0d want 1", lat); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_amt0;
        int lat, bn; logic [7:0] qd;
        run_cmd(2'b00, 3'd0, 8'h5A, -1, lat, bn, qd);
        total_cnt++; if (lat !== 0) $display("FAIL amt0_latency: got %0d want 0", lat); else pass_cnt++;
        total_cnt++; if (bn !== 1) $display("FAIL amt0_busy_cycles: got %0d want 1", bn); else pass_cnt++;
        total_cnt++; if (qd !== 8'h5A) $display("FAIL amt0_q: got %h want 5a", qd); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_ignore;
        int lat, bn; logic [7:0] qd;
        run_cmd(2'b00, 3'd7, 8'h01, 2, lat, bn, qd);
        total_cnt++; if (qd !== 8'h80) $display("FAIL ignore_q: got %h want 80", qd); else pass_cnt++;
        total_cnt++; if (lat !== 7) $display("FAIL ignore_latency: got %0d want 7", lat); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || q !== 8'h80)
            $display("FAIL ignore_no_queue: got busy=%b q=%h want 0 80", busy, q); else pass_cnt++;
    endtask

    task automatic test_abort;
        logic saw_done;
        saw_done = 1'b0;
        start = 1'b1; op = 2'b00; amt = 3'd7; d_in = 8'h01;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        total_cnt++; if (q !== 8'h10) $display("FAIL abort_pre_q: got %h want 10", q); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_immediate: got q=%h busy=%b done=%b want 00 0 0", q, busy, done); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        total_cnt++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got activity=%b want 0", saw_done); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int k;
        start = 1'b1; op = 2'b00; amt = 3'd1; d_in = 8'h03;
        @(negedge clk);
        k = 0;
        while (done !== 1'b1 && k < 30) begin @(negedge clk); k++; end
        total_cnt++; if (k !== 1 || q !== 8'h06)
            $display("FAIL b2b_first: got lat=%0d q=%h want 1 06", k, q); else pass_cnt++;
        op = 2'b01; amt = 3'd2; d_in = 8'h81;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
        k = 0;
        while (done !== 1'b1 && k < 30) begin @(negedge clk); k++; end
        total_cnt++; if (k !== 3 || q !== 8'h20)
            $display("FAIL b2b_second: got lat=%0d q=%h want 3 20", k, q); else pass_cnt++;
        start = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_end: got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_asr_lsr();
        test_rot();
        test_amt0();
        test_ignore();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
